// File: rtl/eth_tx_frame_arb.sv
// Frame-level round-robin arbiter feeding one 8-bit MAC TX AXI-stream from S_COUNT sources.
// A grant is held from the first beat to tlast; frames longer than MAX_LEN are cut and the remainder drained.
module eth_tx_frame_arb #(
    parameter  int S_COUNT    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_LEN    = 1518,
    parameter  int LEN_WIDTH  = 16,
    localparam int SEL_WIDTH  = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT-1:0]            s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic [S_COUNT-1:0]            cfg_port_enable,
    output logic                          grant_valid,
    output logic [SEL_WIDTH-1:0]          grant_index,
    output logic                          stat_truncated
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_WIDTH-1:0]   grant_d;
    logic [LEN_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic                   stat_d;

    logic [S_COUNT-1:0]     req;
    logic                   req_found;
    logic [SEL_WIDTH-1:0]   req_pick;
    int                     scan_idx;

    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   sel_user;
    logic                   at_limit;
    logic [SEL_WIDTH-1:0]   next_ptr;

    // Rotating priority scan: first requester at or after rr_ptr, wrapping modulo S_COUNT.
    always_comb begin
        req       = s_axis_tvalid & cfg_port_enable;
        req_found = 1'b0;
        req_pick  = rr_ptr_q;
        scan_idx  = 0;
        for (int i = 0; i < S_COUNT; i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= S_COUNT) begin
                scan_idx = scan_idx - S_COUNT;
            end
            if (!req_found && req[scan_idx]) begin
                req_found = 1'b1;
                req_pick  = SEL_WIDTH'(scan_idx);
            end
        end
    end

    assign sel_data  = s_axis_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
    assign sel_valid = s_axis_tvalid[grant_index];
    assign sel_last  = s_axis_tlast[grant_index];
    assign sel_user  = s_axis_tuser[grant_index];
    assign at_limit  = (byte_cnt_q == LEN_WIDTH'(MAX_LEN - 1));
    assign next_ptr  = (grant_index == SEL_WIDTH'(S_COUNT - 1)) ? '0 : grant_index + 1'b1;

    assign grant_valid = (state_q != ST_IDLE);

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_index;
        byte_cnt_d    = byte_cnt_q;
        stat_d        = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    grant_d    = req_pick;
                    byte_cnt_d = '0;
                    state_d    = ST_PASS;
                end
            end

            ST_PASS: begin
                m_axis_tdata               = sel_data;
                m_axis_tvalid              = sel_valid;
                m_axis_tlast               = sel_last | at_limit;
                m_axis_tuser               = sel_user | (at_limit & ~sel_last);
                s_axis_tready[grant_index] = m_axis_tready;
                if (sel_valid && m_axis_tready) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (sel_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_ptr;
                    end else if (at_limit) begin
                        state_d = ST_DRAIN;
                        stat_d  = 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                // Remainder of a truncated frame is swallowed; the MAC already saw tlast+tuser.
                s_axis_tready[grant_index] = 1'b1;
                if (sel_valid && sel_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            grant_index    <= '0;
            byte_cnt_q     <= '0;
            stat_truncated <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_index    <= grant_d;
            byte_cnt_q     <= byte_cnt_d;
            stat_truncated <= stat_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Randomized bench for eth_tx_frame_arb: per-port frame queues drive the sources and a
// frame-level arbitration model predicts grants, forwarded beats, truncation and drain.
module tb_eth_tx_frame_arb;

    localparam int S       = 4;
    localparam int DW      = 8;
    localparam int MAX_LEN = 8;
    localparam int DEPTH   = 256;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic            clk;
    logic            rst;
    logic [S*DW-1:0] s_axis_tdata;
    logic [S-1:0]    s_axis_tvalid;
    logic [S-1:0]    s_axis_tready;
    logic [S-1:0]    s_axis_tlast;
    logic [S-1:0]    s_axis_tuser;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic [S-1:0]    cfg_port_enable;
    logic            grant_valid;
    logic [1:0]      grant_index;
    logic            stat_truncated;

    eth_tx_frame_arb #(
        .S_COUNT   (S),
        .DATA_WIDTH(DW),
        .MAX_LEN   (MAX_LEN),
        .LEN_WIDTH (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .cfg_port_enable(cfg_port_enable),
        .grant_valid    (grant_valid),
        .grant_index    (grant_index),
        .stat_truncated (stat_truncated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Source frame storage and driver state
    beat_t      mem [S][DEPTH];
    int         n   [S];
    int         ptr [S];
    logic [S-1:0] drv_valid;
    int         p_valid;
    int         ready_mode;
    int         cyc;
    int         trunc_gen;
    int         stat_seen;

    // Frame-level reference model
    bit         m_busy;
    bit         m_drain;
    int         m_g;
    int         m_rr;
    int         m_bytes;
    bit         m_stat;

    task automatic add_frame(input int p, input int len, input bit bad_frame);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = 8'($urandom);
            b.last = (k == len - 1);
            b.user = bad_frame && (k == len - 1);
            mem[p][n[p]] = b;
            n[p]++;
        end
        if (len > MAX_LEN) trunc_gen++;
    endtask

    task automatic apply_drive();
        for (int i = 0; i < S; i++) begin
            s_axis_tvalid[i] = drv_valid[i];
            if (ptr[i] < n[i]) begin
                s_axis_tdata[i*DW +: DW] = mem[i][ptr[i]].data;
                s_axis_tlast[i]          = mem[i][ptr[i]].last;
                s_axis_tuser[i]          = mem[i][ptr[i]].user;
            end else begin
                s_axis_tdata[i*DW +: DW] = '0;
                s_axis_tlast[i]          = 1'b0;
                s_axis_tuser[i]          = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_drain = 0;
        m_g     = 0;
        m_rr    = 0;
        m_bytes = 0;
        m_stat  = 0;
    endtask

    // One clock: compare at negedge, advance the model, then update drivers just after posedge.
    task automatic step();
        logic [S-1:0] exp_ready;
        logic [S-1:0] hs;
        logic [S-1:0] req;
        logic         exp_mvalid;
        beat_t        b;
        bit           lim;

        @(negedge clk);
        check("grant_valid", grant_valid, m_busy);
        if (m_busy) check("grant_index", grant_index, m_g);
        check("stat_truncated", stat_truncated, m_stat);
        if (stat_truncated) stat_seen++;

        exp_ready  = '0;
        exp_mvalid = 1'b0;
        if (m_busy && !m_drain) begin
            exp_ready[m_g] = m_axis_tready;
            exp_mvalid     = drv_valid[m_g];
        end else if (m_busy) begin
            exp_ready[m_g] = 1'b1;
        end
        check("s_tready", s_axis_tready, exp_ready);
        check("m_tvalid", m_axis_tvalid, exp_mvalid);
        if (exp_mvalid) begin
            b   = mem[m_g][ptr[m_g]];
            lim = (m_bytes == MAX_LEN - 1);
            check("m_tdata", m_axis_tdata, b.data);
            check("m_tlast", m_axis_tlast, b.last | lim);
            check("m_tuser", m_axis_tuser, b.user | (lim & ~b.last));
        end

        hs     = drv_valid & s_axis_tready;
        m_stat = 0;
        if (!m_busy) begin
            req = drv_valid & cfg_port_enable;
            if (req != '0) begin
                for (int k = 0; k < S; k++) begin
                    int idx;
                    idx = (m_rr + k) % S;
                    if (req[idx]) begin
                        m_g = idx;
                        break;
                    end
                end
                m_busy  = 1;
                m_drain = 0;
                m_bytes = 0;
            end
        end else if (drv_valid[m_g] && exp_ready[m_g]) begin
            b = mem[m_g][ptr[m_g]];
            if (!m_drain) begin
                m_bytes++;
                if (b.last) begin
                    m_busy = 0;
                    m_rr   = (m_g + 1) % S;
                end else if (m_bytes == MAX_LEN) begin
                    m_drain = 1;
                    m_stat  = 1;
                end
            end else if (b.last) begin
                m_busy = 0;
                m_rr   = (m_g + 1) % S;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < S; i++) begin
            if (hs[i]) begin
                ptr[i]++;
                drv_valid[i] = 1'b0;
            end
            if (!drv_valid[i] && ptr[i] < n[i] && $urandom_range(99) < p_valid)
                drv_valid[i] = 1'b1;
        end
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = cyc[0];
            default: m_axis_tready = 1'($urandom_range(1));
        endcase
        apply_drive();
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int  c;
        bit  pending;
        c = 0;
        pending = 1;
        while (pending && c < budget) begin
            step();
            c++;
            pending = m_busy;
            for (int i = 0; i < S; i++) if (ptr[i] < n[i]) pending = 1;
        end
        check(tag, pending, 0);
    endtask

    initial begin
        rst             = 1'b1;
        cfg_port_enable = '0;
        m_axis_tready   = 1'b0;
        drv_valid       = '0;
        p_valid         = 100;
        ready_mode      = 0;
        cyc             = 0;
        trunc_gen       = 0;
        stat_seen       = 0;
        for (int i = 0; i < S; i++) begin
            n[i]   = 0;
            ptr[i] = 0;
        end
        model_reset();
        apply_drive();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_index", grant_index, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_stat", stat_truncated, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two ports, 4-byte frames, MAC always ready
        cfg_port_enable = 4'hF;
        ready_mode      = 0;
        add_frame(0, 4, 0);
        add_frame(1, 4, 0);
        run_until_done("phase_two_port_done", 200);

        // All ports busy: random lengths, explicit truncated and exact-MAX_LEN frames
        p_valid = 100;
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < S; p++) add_frame(p, 3, 0);
        run_until_done("phase_rr_done", 400);

        p_valid    = 80;
        ready_mode = 2;
        add_frame(2, 12, 0);
        add_frame(3, 8, 0);
        for (int f = 0; f < 5; f++)
            for (int p = 0; p < S; p++)
                add_frame(p, $urandom_range(12, 1), 1'($urandom_range(1)));
        run_until_done("phase_random_done", 3000);

        // Toggling MAC ready with a bad-frame marker on the last beat
        p_valid    = 100;
        ready_mode = 1;
        add_frame(2, 6, 1);
        add_frame(1, 5, 0);
        run_until_done("phase_toggle_done", 200);
        check("trunc_count", stat_seen, trunc_gen);

        // Only port 0 enabled: port 1 must never be granted
        ready_mode      = 0;
        cfg_port_enable = 4'b0001;
        add_frame(1, 4, 0);
        add_frame(0, 6, 0);
        for (int c = 0; c < 30; c++) step();
        check("disabled_port_untouched", ptr[1], n[1] - 4);

        // Reset in the middle of a frame
        add_frame(0, 12, 0);
        begin
            int c;
            c = 0;
            while (!(m_busy && m_bytes >= 3) && c < 200) begin
                step();
                c++;
            end
            check("midframe_reached", (m_busy && m_bytes >= 3), 1);
        end
        rst       = 1'b1;
        drv_valid = '0;
        for (int i = 0; i < S; i++) ptr[i] = n[i];
        apply_drive();
        @(negedge clk);
        check("midrst_m_tvalid", m_axis_tvalid, 0);
        check("midrst_s_tready", s_axis_tready, 0);
        check("midrst_grant_valid", grant_valid, 0);
        check("midrst_grant_index", grant_index, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // After reset the pointer restarts at 0: port 1 wins over port 3
        cfg_port_enable = 4'hF;
        add_frame(3, 4, 0);
        add_frame(1, 4, 0);
        run_until_done("phase_post_reset_done", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
